// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, holds it for LATENCY wait cycles,
// commits it to an internal word RAM and returns data or an error on a response channel.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int          BYTE_AW    = IDX_W + 2;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT        = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and response payload is held until its transfer.

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept, commit;
  logic             c_write, c_err;
  logic [31:0]      c_addr, c_wdata;
  logic [3:0]       c_wstrb;
  logic [IDX_W-1:0] c_idx;

  assign accept = req_valid_i && (state_q == S_IDLE);

  // With LATENCY=0 the commit happens on the accept edge, so use the live request.
  always_comb begin
    c_write = write_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_wstrb = wstrb_q;
    if (state_q == S_IDLE) begin
      c_write = req_write_i;
      c_addr  = req_addr_i;
      c_wdata = req_wdata_i;
      c_wstrb = req_wstrb_i;
    end
    c_err = (c_addr[1:0] != 2'b00) || (c_addr >= ADDR_LIMIT);
    c_idx = c_addr[BYTE_AW-1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LAT == 4'd0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = c_err;
      rdata_d = (!c_write && !c_err) ? mem_q[c_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
    end
  end

  // RAM is not reset; gating with rst_n keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (commit && rst_n && c_write && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wstrb[b]) mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two builds (LATENCY=2/256 words, LATENCY=0/16 words)
// driven with directed and random loads/stores, checked by a queue-based scoreboard.
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;
  localparam int DEP0 = 256;
  localparam int DEP1 = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_wstrb  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [1:0]  dbg_state  [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [31:0] ref_mem [2][256];
  bit          busy    [2];
  bit          waiting [2];
  int          lat_cnt [2];
  bit          force_rdy, hold_lo;
  int          checks, errors, cyc;

  dmem_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wstrb_i(req_wstrb[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .dbg_state_o(dbg_state[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wstrb_i(req_wstrb[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .dbg_state_o(dbg_state[1])
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [32:0] model(input int d, input bit wr, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] s);
    longint limit = 4 * dep_of(d);
    int     idx;
    if (a % 4 != 0 || longint'(a) >= limit) return {1'b1, 32'h0};
    idx = int'(a / 4);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, ref_mem[d][idx]};
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input bit track, output int acc_cyc);
    int n = 0;
    logic [32:0] e;
    acc_cyc      = -1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_wstrb[d] = s;
    req_valid[d] = 1'b1;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b, required 1 within 200 cycles", d, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    busy[d] = 1'b1;
    if (track) begin
      e = model(d, wr, a, wd, s);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      waiting[d] = 1'b1;
      lat_cnt[d] = 0;
    end
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (((d == 0 ? exp_q0.size() : exp_q1.size()) != 0 || busy[d]) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: responses still pending after 500 cycles", d);
    end
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        resp_ready[d] = force_rdy ? 1'b1 : (hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int d);
    logic [32:0] e;
    bit          have;
    checks++;
    if (req_ready[d] !== !busy[d]) begin
      errors++;
      $display("FAIL req_ready dut%0d cyc %0d: got %b, required %b", d, cyc, req_ready[d], !busy[d]);
    end
    if (waiting[d]) lat_cnt[d]++;
    if (resp_valid[d] === 1'b1) begin
      if (waiting[d]) begin
        checks++;
        if (lat_cnt[d] != lat_of(d) + 1) begin
          errors++;
          $display("FAIL latency dut%0d: resp_valid after %0d edges, required %0d",
                   d, lat_cnt[d], lat_of(d) + 1);
        end
        waiting[d] = 1'b0;
      end
      have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_resp dut%0d: err=%b rdata=%h with nothing expected",
                 d, resp_err[d], resp_rdata[d]);
        if (resp_ready[d]) busy[d] = 1'b0;
      end else begin
        e = (d == 0) ? exp_q0[0] : exp_q1[0];
        if ({resp_err[d], resp_rdata[d]} !== e) begin
          errors++;
          $display("FAIL resp dut%0d cyc %0d: err=%b rdata=%h, required err=%b rdata=%h",
                   d, cyc, resp_err[d], resp_rdata[d], e[32], e[31:0]);
        end
        if (resp_ready[d]) begin
          if (d == 0) void'(exp_q0.pop_front());
          else        void'(exp_q1.pop_front());
          busy[d] = 1'b0;
        end
      end
    end else if (waiting[d] && lat_cnt[d] > lat_of(d) + 1) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout dut%0d: resp_valid=0 after %0d edges, required 1 at %0d",
               d, lat_cnt[d], lat_of(d) + 1);
      waiting[d] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1)
        for (int d = 0; d < 2; d++) mon(d);
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || resp_rdata[d] !== 32'h0 ||
          resp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d: valid=%b ready=%b rdata=%h err=%b, required 0/1/0/0",
                 tag, d, resp_valid[d], req_ready[d], resp_rdata[d], resp_err[d]);
      end
    end
  endtask

  task automatic throughput(input int d);
    int ac, prev;
    wait_idle(d);
    force_rdy = 1'b1;
    @(posedge clk);
    #1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      issue(d, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b1, ac);
      if (prev >= 0) begin
        checks++;
        if (ac - prev != lat_of(d) + 2) begin
          errors++;
          $display("FAIL throughput dut%0d: accept gap %0d, required %0d", d, ac - prev, lat_of(d) + 2);
        end
      end
      prev = ac;
    end
    wait_idle(d);
    force_rdy = 1'b0;
  endtask

  task automatic random_ops(input int d, input int n);
    int          ac, r;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'(4 * $urandom_range(0, dep_of(d) - 1) + $urandom_range(1, 3));
      else if (r == 1) a = 32'(4 * dep_of(d)) + ($urandom_range(0, 4000) << 2);
      else             a = 32'(4 * $urandom_range(0, dep_of(d) - 1));
      issue(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1, ac);
    end
  endtask

  initial begin
    int ac;
    checks = 0; errors = 0; cyc = 0;
    force_rdy = 1'b0; hold_lo = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_wstrb[d] = 4'h0; resp_ready[d] = 1'b0;
      busy[d] = 1'b0; waiting[d] = 1'b0; lat_cnt[d] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < dep_of(d); i++) issue(d, 1'b1, 32'(4 * i), $urandom, 4'hF, 1'b1, ac);

    // store/load, byte strobe merge, wstrb=0 no-op
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, ac);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, ac);
    issue(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b1, ac);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, ac);
    issue(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 1'b1, ac);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, ac);

    // backpressure: response held while resp_ready stays low
    wait_idle(0);
    hold_lo = 1'b1;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, ac);
    repeat (8) @(posedge clk);
    #1 hold_lo = 1'b0;

    // error cases, RAM must be untouched
    issue(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, ac);
    issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, ac);
    issue(0, 1'b1, 32'h3, 32'hFFFFFFFF, 4'hF, 1'b1, ac);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, ac);
    issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1, ac);

    // reset while the store is in WAIT drops it
    wait_idle(0);
    wait_idle(1);
    issue(0, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, ac);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_wait");
    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; waiting[d] = 1'b0;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, ac);

    throughput(0);
    random_ops(0, 300);

    issue(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 1'b1, ac);
    issue(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, ac);
    issue(1, 1'b1, 32'h8, 32'h11223344, 4'b1010, 1'b1, ac);
    issue(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, ac);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, ac);
    throughput(1);
    random_ops(1, 150);

    wait_idle(0);
    wait_idle(1);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
